// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU core: opcodes, FSM states and
// instruction field positions.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned IMM_W   = 16;

  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_LSB = 9;
  localparam int unsigned RD_LSB  = 12;
  localparam int unsigned HL_POS  = 15;
  localparam int unsigned IMM_LSB = 16;

  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd2;
  localparam logic [OP_W-1:0] OP_AND   = 6'd3;
  localparam logic [OP_W-1:0] OP_OR    = 6'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd5;
  localparam logic [OP_W-1:0] OP_LDI   = 6'd6;
  localparam logic [OP_W-1:0] OP_STORE = 6'd7;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'd8;
  localparam logic [OP_W-1:0] OP_BRF   = 6'd9;
  localparam logic [OP_W-1:0] OP_JR    = 6'd10;
  localparam logic [OP_W-1:0] OP_HALT  = 6'd11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  // Ops that write rd and its flag in WB.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_LOAD: return 1'b1;
      OP_NOP, OP_STORE, OP_BRF, OP_JR, OP_HALT:               return 1'b0;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic/logic ops and LDI half-word merge, with flag.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  input  logic              hl,
  input  logic [DATA_W-1:0] rd_old,
  output logic [DATA_W-1:0] result,
  output logic              flag
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    flag   = 1'b0;
    case (op)
      OP_ADD: begin result = sum[DATA_W-1:0]; flag = sum[DATA_W]; end
      OP_SUB: begin result = a - b; flag = (a < b); end
      OP_AND: begin result = a & b; flag = (result == '0); end
      OP_OR:  begin result = a | b; flag = (result == '0); end
      OP_XOR: begin result = a ^ b; flag = (result == '0); end
      OP_LDI: begin
        result = rd_old;
        if (hl) result[2*IMM_W-1:IMM_W] = imm;
        else    result[IMM_W-1:0]       = imm;
        flag = (result == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle CPU core with req/ack memory handshake, run/halt control and
// retire/illegal status pulses.
module cpu_mc_core
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              illegal,
  output logic              halted
);

  localparam int unsigned RIDX_W = $clog2(NREGS);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt, tgt_q, tgt_nxt, addr_nxt;
  logic                tgt_vld_q, tgt_vld_nxt;
  logic [INSTR_W-1:0]  instr, instr_nxt;
  logic [DATA_W-1:0]   res_q, res_nxt, wdata_nxt;
  logic                rflag_q, rflag_nxt;
  logic                req_nxt, we_nxt, retire_nxt, illegal_nxt, halted_nxt, wr_en;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [NREGS-1:0]    flags;

  logic [OP_W-1:0]     op;
  logic [RIDX_W-1:0]   rs1, rs2, rd;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_flag;

  assign op     = instr[OP_LSB  +: OP_W];
  assign rs1    = instr[RS1_LSB +: RIDX_W];
  assign rs2    = instr[RS2_LSB +: RIDX_W];
  assign rd     = instr[RD_LSB  +: RIDX_W];
  assign pc_out = pc;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (regs[rs1]),
    .b      (regs[rs2]),
    .imm    (instr[IMM_LSB +: IMM_W]),
    .hl     (instr[HL_POS]),
    .rd_old (regs[rd]),
    .result (alu_res),
    .flag   (alu_flag)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = instr;
    res_nxt     = res_q;
    rflag_nxt   = rflag_q;
    tgt_nxt     = tgt_q;
    tgt_vld_nxt = tgt_vld_q;
    req_nxt     = mem_req;
    we_nxt      = mem_we;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    retire_nxt  = 1'b0;
    illegal_nxt = 1'b0;
    halted_nxt  = halted;
    wr_en       = 1'b0;
    unique case (state)
      S_IDLE: if (run) begin
        state_nxt = S_FETCH;
        req_nxt   = 1'b1;
        we_nxt    = 1'b0;
        addr_nxt  = pc;
      end
      S_FETCH: if (mem_ack) begin
        instr_nxt   = mem_rdata[INSTR_W-1:0];
        pc_nxt      = pc + ADDR_W'(1);
        req_nxt     = 1'b0;
        illegal_nxt = (mem_rdata[OP_LSB +: OP_W] > OP_HALT);
        state_nxt   = S_EXEC;
      end
      S_EXEC: begin
        res_nxt     = alu_res;
        rflag_nxt   = alu_flag;
        tgt_vld_nxt = 1'b0;
        case (op)
          OP_LOAD: begin
            state_nxt = S_MEM;
            req_nxt   = 1'b1;
            we_nxt    = 1'b0;
            addr_nxt  = ADDR_W'(regs[rs1]);
          end
          OP_STORE: begin
            state_nxt = S_MEM;
            req_nxt   = 1'b1;
            we_nxt    = 1'b1;
            addr_nxt  = ADDR_W'(regs[rs2]);
            wdata_nxt = regs[rs1];
          end
          OP_HALT: begin
            state_nxt  = S_HALT;
            halted_nxt = 1'b1;
            retire_nxt = 1'b1;
          end
          default: begin
            if (op == OP_BRF && flags[rs1]) begin
              tgt_vld_nxt = 1'b1;
              tgt_nxt     = ADDR_W'(instr[IMM_LSB +: IMM_W]);
            end else if (op == OP_JR) begin
              tgt_vld_nxt = 1'b1;
              tgt_nxt     = ADDR_W'(regs[rs2]);
            end
            state_nxt  = S_WB;
            retire_nxt = 1'b1;
          end
        endcase
      end
      S_MEM: if (mem_ack) begin
        req_nxt    = 1'b0;
        we_nxt     = 1'b0;
        state_nxt  = S_WB;
        retire_nxt = 1'b1;
        if (op == OP_LOAD) begin
          res_nxt   = mem_rdata;
          rflag_nxt = (mem_rdata == '0);
        end
      end
      S_WB: begin
        wr_en = op_writes(op);
        if (tgt_vld_q) pc_nxt = tgt_q;
        if (run) begin
          state_nxt = S_FETCH;
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          addr_nxt  = pc_nxt;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_HALT: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr     <= '0;
      res_q     <= '0;
      rflag_q   <= 1'b0;
      tgt_q     <= '0;
      tgt_vld_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
      flags     <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr     <= instr_nxt;
      res_q     <= res_nxt;
      rflag_q   <= rflag_nxt;
      tgt_q     <= tgt_nxt;
      tgt_vld_q <= tgt_vld_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      retire    <= retire_nxt;
      illegal   <= illegal_nxt;
      halted    <= halted_nxt;
      if (wr_en) begin
        regs[rd]  <= res_q;
        flags[rd] <= rflag_q;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mc_core.sv
// Directed bench for cpu_mc_core: a 32-bit/8-register core and an
// 8-bit-address/2-register core, driven one at a time through a shared memory port.
module tb_cpu_mc_core;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset, run_a, run_b, ack, sel;
  logic [31:0] rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  logic        a_req, a_we, a_retire, a_illegal, a_halted, a_ack;
  logic [31:0] a_addr, a_wdata, a_pc;
  logic        b_req, b_we, b_retire, b_illegal, b_halted, b_ack;
  logic [7:0]  b_addr, b_pc;
  logic [31:0] b_wdata;

  assign a_ack = ack & ~sel;
  assign b_ack = ack & sel;

  cpu_mc_core #(.DATA_W(32), .ADDR_W(32), .NREGS(8)) u_a (
    .clock(clock), .reset(reset), .run(run_a),
    .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_rdata(rdata), .mem_ack(a_ack), .pc_out(a_pc),
    .retire(a_retire), .illegal(a_illegal), .halted(a_halted)
  );

  cpu_mc_core #(.DATA_W(32), .ADDR_W(8), .NREGS(2)) u_b (
    .clock(clock), .reset(reset), .run(run_b),
    .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_rdata(rdata), .mem_ack(b_ack), .pc_out(b_pc),
    .retire(b_retire), .illegal(b_illegal), .halted(b_halted)
  );

  // Observation mux for whichever core is under test.
  logic        o_req, o_we, o_retire, o_illegal, o_halted;
  logic [31:0] o_addr, o_wdata, o_pc;
  assign o_req     = sel ? b_req     : a_req;
  assign o_we      = sel ? b_we      : a_we;
  assign o_retire  = sel ? b_retire  : a_retire;
  assign o_illegal = sel ? b_illegal : a_illegal;
  assign o_halted  = sel ? b_halted  : a_halted;
  assign o_addr    = sel ? 32'(b_addr) : a_addr;
  assign o_wdata   = sel ? b_wdata   : a_wdata;
  assign o_pc      = sel ? 32'(b_pc) : a_pc;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic hl, input logic [15:0] imm);
    return {imm, hl, rd, rs2, rs1, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered in the FETCH cycle; returns in the EXEC cycle.
  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, ":freq"}, 32'(o_req), 32'd1);
    check({tag, ":faddr"}, o_addr, pc);
    check({tag, ":fwe"}, 32'(o_we), 32'd0);
    rdata = ins;
    ack   = 1'b1;
    tick();
    ack   = 1'b0;
    rdata = 32'd0;
  endtask

  task automatic alu(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    fetch(tag, pc, ins);
    check({tag, ":ereq"}, 32'(o_req), 32'd0);
    tick();
    check({tag, ":retire"}, 32'(o_retire), 32'd1);
    tick();
  endtask

  task automatic mem(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                     input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] load_val, input int waits);
    fetch(tag, pc, ins);
    tick();
    for (int i = 0; i <= waits; i++) begin
      check($sformatf("%s:mreq%0d", tag, i), 32'(o_req), 32'd1);
      check($sformatf("%s:mwe%0d", tag, i), 32'(o_we), 32'(we));
      check($sformatf("%s:maddr%0d", tag, i), o_addr, addr);
      if (we) check($sformatf("%s:mwdata%0d", tag, i), o_wdata, wdata);
      if (i == waits) begin
        ack   = 1'b1;
        rdata = load_val;
      end
      tick();
    end
    ack   = 1'b0;
    rdata = 32'd0;
    check({tag, ":wbreq"}, 32'(o_req), 32'd0);
    check({tag, ":retire"}, 32'(o_retire), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; run_a = 1'b0; run_b = 1'b0; ack = 1'b0; rdata = 32'd0;
    reset = 1'b1;
    #2 reset = 1'b0;
    tick(); tick();
    check("rst:req", 32'(o_req), 32'd0);
    check("rst:we", 32'(o_we), 32'd0);
    check("rst:addr", o_addr, 32'd0);
    check("rst:wdata", o_wdata, 32'd0);
    check("rst:retire", 32'(o_retire), 32'd0);
    check("rst:illegal", 32'(o_illegal), 32'd0);
    check("rst:halted", 32'(o_halted), 32'd0);
    check("rst:pc", o_pc, 32'd0);

    // Idle with run low; a stray ack must be ignored.
    reset = 1'b1;
    ack   = 1'b1;
    rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("idle:req%0d", i), 32'(o_req), 32'd0);
    end
    ack   = 1'b0;
    rdata = 32'd0;
    run_a = 1'b1;
    tick();

    alu("ldi_r0l", 32'd0, enc(OP_LDI, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFFFF));
    alu("ldi_r0h", 32'd1, enc(OP_LDI, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF));
    alu("ldi_r1l", 32'd2, enc(OP_LDI, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0001));
    alu("add_r2", 32'd3, enc(OP_ADD, 3'd2, 3'd0, 3'd1, 1'b0, 16'h0));
    alu("ldi_r3l", 32'd4, enc(OP_LDI, 3'd3, 3'd0, 3'd0, 1'b0, 16'h0040));
    mem("st_r1", 32'd5, enc(OP_STORE, 3'd0, 3'd1, 3'd3, 1'b0, 16'h0), 1'b1, 32'h40, 32'd1, 32'd0, 3);
    mem("ld_r4", 32'd6, enc(OP_LOAD, 3'd4, 3'd3, 3'd0, 1'b0, 16'h0), 1'b0, 32'h40, 32'd0, 32'd1, 3);
    mem("st_r4", 32'd7, enc(OP_STORE, 3'd0, 3'd4, 3'd3, 1'b0, 16'h0), 1'b1, 32'h40, 32'd1, 32'd0, 0);
    mem("st_r2", 32'd8, enc(OP_STORE, 3'd0, 3'd2, 3'd3, 1'b0, 16'h0), 1'b1, 32'h40, 32'd0, 32'd0, 0);
    alu("brf_tk", 32'd9, enc(OP_BRF, 3'd0, 3'd2, 3'd0, 1'b0, 16'h0010));
    alu("brf_nt", 32'h10, enc(OP_BRF, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0030));

    fetch("ill", 32'h11, enc(6'h3F, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0));
    check("ill:pulse", 32'(o_illegal), 32'd1);
    check("ill:noret", 32'(o_retire), 32'd0);
    tick();
    check("ill:drop", 32'(o_illegal), 32'd0);
    check("ill:retire", 32'(o_retire), 32'd1);
    tick();

    mem("st_r4b", 32'h12, enc(OP_STORE, 3'd0, 3'd4, 3'd3, 1'b0, 16'h0), 1'b1, 32'h40, 32'd1, 32'd0, 0);
    alu("sub_r5", 32'h13, enc(OP_SUB, 3'd5, 3'd1, 3'd0, 1'b0, 16'h0));
    alu("brf_r5", 32'h14, enc(OP_BRF, 3'd0, 3'd5, 3'd0, 1'b0, 16'h0020));
    alu("xor_r6", 32'h20, enc(OP_XOR, 3'd6, 3'd0, 3'd1, 1'b0, 16'h0));
    mem("st_r6", 32'h21, enc(OP_STORE, 3'd0, 3'd6, 3'd3, 1'b0, 16'h0), 1'b1, 32'h40, 32'hFFFF_FFFE, 32'd0, 0);
    mem("st_r5", 32'h22, enc(OP_STORE, 3'd0, 3'd5, 3'd3, 1'b0, 16'h0), 1'b1, 32'h40, 32'd2, 32'd0, 0);
    alu("and_r7", 32'h23, enc(OP_AND, 3'd7, 3'd0, 3'd3, 1'b0, 16'h0));
    mem("st_r7", 32'h24, enc(OP_STORE, 3'd0, 3'd7, 3'd3, 1'b0, 16'h0), 1'b1, 32'h40, 32'h40, 32'd0, 0);

    fetch("halt", 32'h25, enc(OP_HALT, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0));
    tick();
    check("halt:halted", 32'(o_halted), 32'd1);
    check("halt:retire", 32'(o_retire), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("halt:req%0d", i), 32'(o_req), 32'd0);
      check($sformatf("halt:ret%0d", i), 32'(o_retire), 32'd0);
    end
    check("halt:stay", 32'(o_halted), 32'd1);

    // Reset clears HALT; a second reset during a stalled fetch drops mem_req at once.
    reset = 1'b0;
    #1;
    check("rst2:req", 32'(o_req), 32'd0);
    check("rst2:halted", 32'(o_halted), 32'd0);
    check("rst2:pc", o_pc, 32'd0);
    reset = 1'b1;
    tick();
    check("rf:req", 32'(o_req), 32'd1);
    check("rf:addr", o_addr, 32'd0);
    tick();
    check("rf:hold", 32'(o_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rf:async", 32'(o_req), 32'd0);
    #2 reset = 1'b1;
    tick();
    check("rf:rereq", 32'(o_req), 32'd1);
    check("rf:readdr", o_addr, 32'd0);
    check("rf:pc", o_pc, 32'd0);

    // Narrow core: 8-bit PC, two registers.
    sel   = 1'b1;
    run_b = 1'b1;
    tick();
    alu("b_ldi1", 32'd0, enc(OP_LDI, 3'd1, 3'd0, 3'd0, 1'b0, 16'hFFFF));
    alu("b_ldi7", 32'd1, enc(OP_LDI, 3'd7, 3'd0, 3'd0, 1'b1, 16'hFFFF));
    mem("b_st", 32'd2, enc(OP_STORE, 3'd0, 3'd3, 3'd6, 1'b0, 16'h0), 1'b1, 32'd0, 32'hFFFF_FFFF, 32'd0, 0);
    alu("b_jr", 32'd3, enc(OP_JR, 3'd0, 3'd0, 3'd5, 1'b0, 16'h0));
    fetch("b_wrap", 32'hFF, enc(OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0));
    check("b_wrap:pc", o_pc, 32'd0);
    run_b = 1'b0;
    tick();
    check("b_stop:retire", 32'(o_retire), 32'd1);
    tick();
    check("b_stop:idle0", 32'(o_req), 32'd0);
    tick();
    check("b_stop:idle1", 32'(o_req), 32'd0);
    run_b = 1'b1;
    tick();
    check("b_resume:req", 32'(o_req), 32'd1);
    check("b_resume:addr", o_addr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
